// File: rtl/bitstream_loader.sv
// rtl/bitstream_loader.sv - byte-fed serial loader for the configuration chain, with loopback readback
module bitstream_loader #(
  parameter int CHAIN_BITS = 17
) (
  input  logic       clk,
  input  logic       nn_reset,
  input  logic       start,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  input  logic       bs_ret,
  output logic       bs_out,
  output logic       conf_en,
  output logic [7:0] rb_byte,
  output logic       rb_valid,
  output logic       busy,
  output logic       done
);

  localparam int            CW      = $clog2(CHAIN_BITS + 1);
  localparam logic [CW-1:0] LP_LAST = CW'(CHAIN_BITS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_BYTE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_bit_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic [7:0]    r_cap;
  logic [7:0]    r_rb_byte;
  logic          r_rb_valid;

  logic [CW-1:0] w_cnt_inc;
  logic          w_last_bit;
  logic          w_byte_end;
  logic [7:0]    w_cap_next;

  assign w_cnt_inc  = r_bit_cnt + CW'(1);
  assign w_last_bit = (w_cnt_inc == LP_LAST);
  assign w_byte_end = (r_idx == 3'd7);
  assign w_cap_next = {r_cap[6:0], bs_ret};

  assign rb_byte  = r_rb_byte;
  assign rb_valid = r_rb_valid;

  always_ff @(posedge clk) begin
    if (nn_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // The chain-end test wins over the byte-end test so trailing pad bits of the last byte are dropped.
  always_comb begin
    w_next     = r_state;
    byte_ready = 1'b0;
    conf_en    = 1'b0;
    bs_out     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = S_WAIT_BYTE;
        end
      end
      S_WAIT_BYTE: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid) begin
          w_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        conf_en = 1'b1;
        busy    = 1'b1;
        bs_out  = r_shift[3'd7 - r_idx];
        if (w_last_bit) begin
          w_next = S_DONE;
        end else if (w_byte_end) begin
          w_next = S_WAIT_BYTE;
        end
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Readback bytes are left-aligned so a short final byte lines up with the bits that were written.
  always_ff @(posedge clk) begin
    if (nn_reset) begin
      r_bit_cnt  <= '0;
      r_idx      <= 3'd0;
      r_shift    <= 8'h00;
      r_cap      <= 8'h00;
      r_rb_byte  <= 8'h00;
      r_rb_valid <= 1'b0;
    end else begin
      r_rb_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_bit_cnt <= '0;
            r_cap     <= 8'h00;
          end
        end
        S_WAIT_BYTE: begin
          if (byte_valid) begin
            r_shift <= byte_in;
            r_idx   <= 3'd0;
          end
        end
        S_SHIFT: begin
          r_idx     <= r_idx + 3'd1;
          r_bit_cnt <= w_cnt_inc;
          r_cap     <= w_cap_next;
          if (w_last_bit || w_byte_end) begin
            r_rb_byte  <= w_cap_next << (3'd7 - r_idx);
            r_rb_valid <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bitstream_loader.sv
// tb/tb_bitstream_loader.sv - directed scoreboard bench for bitstream_loader (17-bit and 8-bit chains)
module tb_bitstream_loader;

  localparam int CHAIN = 17;
  localparam int LIMIT = 300;

  logic       clk;
  logic       nn_reset, start, byte_valid, bs_ret;
  logic [7:0] byte_in;
  logic       byte_ready, bs_out, conf_en, rb_valid, busy, done;
  logic [7:0] rb_byte;

  logic       e_reset, e_start, e_byte_valid, e_bs_ret;
  logic [7:0] e_byte_in;
  logic       e_byte_ready, e_bs_out, e_conf_en, e_rb_valid, e_busy, e_done;
  logic [7:0] e_rb_byte;

  int n_checks = 0;
  int n_errors = 0;
  int g_cfg, g_done, pushed;
  logic       q_bits[$];
  logic [7:0] q_rb[$];

  assign bs_ret   = bs_out;
  assign e_bs_ret = e_bs_out;

  bitstream_loader #(.CHAIN_BITS(CHAIN)) u_dut (
    .clk(clk), .nn_reset(nn_reset), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .bs_ret(bs_ret),
    .bs_out(bs_out), .conf_en(conf_en), .rb_byte(rb_byte), .rb_valid(rb_valid),
    .busy(busy), .done(done)
  );

  bitstream_loader #(.CHAIN_BITS(8)) u_dut8 (
    .clk(clk), .nn_reset(e_reset), .start(e_start), .byte_in(e_byte_in),
    .byte_valid(e_byte_valid), .byte_ready(e_byte_ready), .bs_ret(e_bs_ret),
    .bs_out(e_bs_out), .conf_en(e_conf_en), .rb_byte(e_rb_byte), .rb_valid(e_rb_valid),
    .busy(e_busy), .done(e_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    int n;
    logic [7:0] m;
    n = ((CHAIN - pushed) < 8) ? (CHAIN - pushed) : 8;
    for (int i = 0; i < n; i++) q_bits.push_back(b[7-i]);
    m = 8'hFF << (8 - n);
    q_rb.push_back(b & m);
    pushed += n;
  endtask

  // One clock of the 17-bit instance; outputs sampled 1 time unit after the edge.
  task automatic cycle();
    logic e;
    @(posedge clk);
    #1;
    if (conf_en === 1'b1) begin
      g_cfg++;
      chk("bit_expected", q_bits.size() > 0, 1);
      if (q_bits.size() > 0) begin
        e = q_bits.pop_front();
        chk("bs_out", bs_out, e);
      end
    end else begin
      chk("bs_out_quiet", bs_out, 0);
    end
    chk("ready_with_conf_en", byte_ready & conf_en, 0);
    if (rb_valid === 1'b1) begin
      chk("rb_expected", q_rb.size() > 0, 1);
      if (q_rb.size() > 0) begin
        chk("rb_byte", rb_byte, q_rb.pop_front());
        if (q_rb.size() == 0 && pushed == CHAIN) chk("rb_last_in_done", done, 1);
      end
    end
    if (done === 1'b1) g_done++;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_byte_ready"}, byte_ready, 0);
    chk({tag, "_conf_en"}, conf_en, 0);
    chk({tag, "_bs_out"}, bs_out, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rb_valid"}, rb_valid, 0);
    chk({tag, "_rb_byte"}, rb_byte, 8'h00);
  endtask

  task automatic run_load(input bit do_hold, input bit do_restart, input int rst_at);
    logic [7:0] bytes [3];
    int  bi, budget;
    bit  xfer, held, restarted, aborted;
    bytes = '{8'hA5, 8'h3C, 8'h80};
    q_bits.delete();
    q_rb.delete();
    pushed = 0; g_cfg = 0; g_done = 0;
    bi = 0; budget = 0; held = 0; restarted = 0; aborted = 0;
    byte_valid = 1'b0;
    start = 1'b1;
    cycle();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    byte_in = bytes[0];
    byte_valid = 1'b1;
    while (g_done == 0 && !aborted && budget < LIMIT) begin
      budget++;
      xfer = byte_ready & byte_valid;
      if (xfer) push_byte(bytes[bi]);
      if (do_restart && !restarted && conf_en && g_cfg == 5) begin
        start = 1'b1;
        restarted = 1;
      end
      cycle();
      start = 1'b0;
      if (xfer) begin
        chk("first_bit_latency", conf_en, 1);
        bi++;
        byte_in = (bi < 3) ? bytes[bi] : 8'h00;
        byte_valid = (bi < 3) && !(do_hold && bi == 1);
      end
      if (do_hold && !held && bi == 1 && byte_ready) begin
        for (int k = 0; k < 5; k++) begin
          chk("hold_byte_ready", byte_ready, 1);
          chk("hold_conf_en", conf_en, 0);
          chk("hold_bs_out", bs_out, 0);
          cycle();
        end
        held = 1;
        byte_valid = 1'b1;
      end
      if (rst_at > 0 && conf_en && g_cfg == rst_at) begin
        nn_reset = 1'b1;
        cycle();
        nn_reset = 1'b0;
        byte_valid = 1'b0;
        check_reset_outputs("abort");
        aborted = 1;
      end
    end
    chk("load_within_budget", budget < LIMIT, 1);
    byte_valid = 1'b0;
    if (aborted) begin
      repeat (4) cycle();
      chk("abort_no_done", g_done, 0);
      chk("abort_idle", busy, 0);
    end else begin
      cycle();
      chk("busy_after_done", busy, 0);
      chk("done_single_cycle", done, 0);
      repeat (3) cycle();
      chk("conf_en_cycles", g_cfg, CHAIN);
      chk("done_count", g_done, 1);
      chk("bits_left", q_bits.size(), 0);
      chk("rb_left", q_rb.size(), 0);
    end
  endtask

  initial begin
    int n8, last8, dcyc8, ndone8, revisit8;
    bit acc_now, accepted8;

    nn_reset = 1'b1; start = 1'b1; byte_valid = 1'b1; byte_in = 8'hA5;
    e_reset = 1'b1; e_start = 1'b0; e_byte_valid = 1'b0; e_byte_in = 8'h00;
    q_bits.delete(); q_rb.delete(); pushed = 0; g_cfg = 0; g_done = 0;
    cycle();
    cycle();
    check_reset_outputs("reset");
    nn_reset = 1'b0; start = 1'b0; byte_valid = 1'b0;
    e_reset = 1'b0;
    cycle();
    chk("idle_after_reset", busy, 0);

    run_load(0, 0, 0);
    run_load(1, 0, 0);
    run_load(0, 1, 0);
    run_load(0, 0, 10);
    run_load(0, 0, 0);

    n8 = 0; last8 = -1; dcyc8 = -1; ndone8 = 0; revisit8 = 0; accepted8 = 0;
    e_start = 1'b1;
    @(posedge clk); #1;
    e_start = 1'b0;
    e_byte_in = 8'hFF;
    e_byte_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      acc_now = e_byte_ready & e_byte_valid;
      @(posedge clk); #1;
      if (acc_now) begin
        accepted8 = 1;
        e_byte_valid = 1'b0;
      end
      if (e_conf_en === 1'b1) begin
        n8++;
        last8 = c;
        chk("c8_bs_out", e_bs_out, 1);
      end
      if (accepted8 && e_byte_ready) revisit8++;
      if (e_done === 1'b1) begin
        ndone8++;
        dcyc8 = c;
        chk("c8_rb_valid_in_done", e_rb_valid, 1);
        chk("c8_rb_byte", e_rb_byte, 8'hFF);
      end
    end
    chk("c8_conf_en_cycles", n8, 8);
    chk("c8_no_wait_revisit", revisit8, 0);
    chk("c8_done_count", ndone8, 1);
    chk("c8_done_after_last_bit", dcyc8, last8 + 1);
    chk("c8_busy_end", e_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bitstream_loader.md
BITSTREAM_LOADER -- requirements
Module: bitstream_loader

Interface
REQ-001 Parameter CHAIN_BITS, default 17, is the total configuration chain length in bits; legal range 1..4095; 17 is one neuron (wA3, wB3, wC3, tSel3, U5).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 nn_reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to begin a chain load.
REQ-005 byte_in  input  8  configuration byte, shifted out MSB first.
REQ-006 byte_valid  input  1  byte_in holds a valid byte.
REQ-007 byte_ready  output  1  loader accepts byte_in this cycle.
REQ-008 bs_ret  input  1  serial return from the chain tail, used for readback.
REQ-009 bs_out  output  1  serial bit to the chain head's bs_in.
REQ-010 conf_en  output  1  chain shift enable; high only in cycles where bs_out is a valid chain bit.
REQ-011 rb_byte  output  8  captured readback byte.
REQ-012 rb_valid  output  1  one-cycle strobe qualifying rb_byte.
REQ-013 busy  output  1  a load is in progress.
REQ-014 done  output  1  one-cycle strobe at load completion.

Function
REQ-015 FSM states SHALL be IDLE, WAIT_BYTE, SHIFT and DONE.
REQ-016 IDLE: start=1 -> WAIT_BYTE with the bit counter cleared; start=0 -> stay in IDLE.
REQ-017 WAIT_BYTE: byte_ready=1 and conf_en=0; byte_valid=1 latches byte_in into the shift byte, clears the in-byte index and goes to SHIFT; otherwise stay, with no timeout.
REQ-018 byte_ready SHALL be 1 only in WAIT_BYTE; a transfer is byte_valid & byte_ready in the same cycle.
REQ-019 SHIFT: conf_en=1 and bs_out = shift byte bit [7-index]; index and bit counter increment every cycle.
REQ-020 SHIFT exit: bit counter reaches CHAIN_BITS -> DONE; else index reaches 8 -> WAIT_BYTE; else stay in SHIFT.
REQ-021 Unused low bits of the final byte (CHAIN_BITS mod 8 != 0) SHALL be discarded and never presented with conf_en=1.
REQ-022 Latency: a byte accepted in cycle t puts its MSB on bs_out with conf_en=1 in cycle t+1; consecutive bytes have a minimum 1-cycle gap with conf_en=0.
REQ-023 conf_en SHALL be high for exactly CHAIN_BITS cycles per load.
REQ-024 When conf_en=0, bs_out SHALL be 0.
REQ-025 DONE: done=1 for one cycle, then IDLE; busy=1 in WAIT_BYTE and SHIFT, 0 in IDLE and DONE.
REQ-026 start outside IDLE SHALL be ignored, with no queuing.
REQ-027 Readback: each SHIFT cycle captures bs_ret into the LSB of an 8-bit capture register, shifting left.
REQ-028 On the 8th captured bit of a byte, rb_byte = capture value and rb_valid=1 in the next cycle.
REQ-029 A final partial readback byte of k bits SHALL be emitted left-aligned, low bits zero, with rb_valid in the DONE cycle.
REQ-030 rb_byte SHALL hold its value between strobes.
REQ-031 The bit counter SHALL be $clog2(CHAIN_BITS+1) bits wide and SHALL never wrap within a load.

Reset
REQ-032 nn_reset=1 at a clock edge SHALL force IDLE from any state, including mid-SHIFT, and clear the counters and capture register.
REQ-033 Values after reset: byte_ready=0, conf_en=0, bs_out=0, busy=0, done=0, rb_valid=0, rb_byte=0x00.
REQ-034 nn_reset has priority over start and byte_valid in the same cycle.
REQ-035 A load aborted by reset SHALL NOT produce done or a partial rb_valid.

Verification
REQ-036 CHAIN_BITS=17, bytes 0xA5, 0x3C, 0x80 always valid -> bs_out under conf_en = 10100101, 00111100, 1; 17 conf_en cycles; done once; busy low after done.
REQ-037 Loopback bs_ret=bs_out, same stimulus -> rb_byte 0xA5, 0x3C, 0x80, the last with rb_valid in the DONE cycle.
REQ-038 byte_valid withheld 5 cycles after the first byte -> conf_en=0, bs_out=0 and byte_ready=1 for those 5 cycles; output bit sequence unchanged.
REQ-039 start pulsed again mid-load -> ignored; exactly 17 conf_en cycles and one done.
REQ-040 nn_reset at the 10th SHIFT cycle -> next cycle all outputs at reset values, no done; a new start then gives a full correct 17-bit load.
REQ-041 CHAIN_BITS=8, byte 0xFF -> 8 conf_en cycles, no WAIT_BYTE revisit, done in the cycle after the last bit.
